// File: rtl/reaction_session_controller.sv
// Multi-round reaction-time session sequencer: random foreperiod, BCD ms timing,
// false-start detection, session-best tracking and session completion.
module reaction_session_controller #(
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned TICKS_PER_MS = 50,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 12,
  parameter int unsigned GAP_MS       = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_trigger,
  input  logic        user_trigger,
  output logic        react,
  output logic        busy,
  output logic [2:0]  round_idx,
  output logic [15:0] result_bcd,
  output logic        result_valid,
  output logic [15:0] best_bcd,
  output logic        false_start,
  output logic [3:0]  false_cnt,
  output logic        timeout,
  output logic        session_done
);

  localparam int unsigned PW       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned FORE_MAX = MIN_DELAY_MS + (32'd1 << RAND_BITS) - 1;
  localparam int unsigned DLY_MAX  = (FORE_MAX > GAP_MS) ? FORE_MAX : GAP_MS;
  localparam int unsigned DW       = $clog2(DLY_MAX + 1);
  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_REACT, S_RECORD, S_GAP, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [DW-1:0]  delay_q, delay_d;
  logic [15:0]    bcd_q, bcd_d;
  logic [2:0]     round_q, round_d;
  logic [15:0]    result_q, result_d;
  logic           result_valid_q, result_valid_d;
  logic [15:0]    best_q, best_d;
  logic           false_start_q, false_start_d;
  logic [3:0]     false_cnt_q, false_cnt_d;
  logic           timeout_q, timeout_d;
  logic           react_q, react_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ms_tick_c;

  // Ripple-carry BCD increment; caller guarantees the input is below 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign ms_tick_c = (presc_q == PW'(TICKS_PER_MS - 1));

  // Free-running Galois LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    bcd_d          = bcd_q;
    round_d        = round_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    best_d         = best_q;
    false_start_d  = 1'b0;
    false_cnt_d    = false_cnt_q;
    timeout_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_trigger) begin
          round_d     = 3'd0;
          false_cnt_d = 4'd0;
          best_d      = BCD_MAX;
          result_d    = 16'h0000;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (user_trigger) begin
          false_start_d = 1'b1;
          if (false_cnt_q != 4'hF) false_cnt_d = false_cnt_q + 4'd1;
          state_d = S_ARM;
        end else if (delay_q == DW'(0)) begin
          bcd_d   = 16'h0000;
          state_d = S_REACT;
        end else if (ms_tick_c) begin
          delay_d = delay_q - DW'(1);
        end
      end
      S_REACT: begin
        // A press beats a same-cycle tick; the recorded value is the current count.
        if (user_trigger || (ms_tick_c && bcd_q == BCD_MAX)) begin
          timeout_d      = !user_trigger;
          result_d       = bcd_q;
          result_valid_d = 1'b1;
          if (bcd_q < best_q) best_d = bcd_q;
          state_d = S_RECORD;
        end else if (ms_tick_c) begin
          bcd_d = bcd_inc(bcd_q);
        end
      end
      S_RECORD: begin
        if (round_q == 3'(ROUNDS - 1)) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 3'd1;
          delay_d = DW'(GAP_MS);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (ms_tick_c) begin
          if (delay_q <= DW'(1)) state_d = S_ARM;
          else                   delay_d = delay_q - DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Prescaler restarts on every state entry so each state sees whole milliseconds.
    if (state_d != state_q || ms_tick_c) presc_d = PW'(0);
    else                                  presc_d = presc_q + PW'(1);

    react_d = (state_d == S_REACT);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= LFSR_SEED;
      presc_q        <= PW'(0);
      delay_q        <= DW'(0);
      bcd_q          <= 16'h0000;
      round_q        <= 3'd0;
      result_q       <= 16'h0000;
      result_valid_q <= 1'b0;
      best_q         <= BCD_MAX;
      false_start_q  <= 1'b0;
      false_cnt_q    <= 4'd0;
      timeout_q      <= 1'b0;
      react_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      presc_q        <= presc_d;
      delay_q        <= delay_d;
      bcd_q          <= bcd_d;
      round_q        <= round_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      best_q         <= best_d;
      false_start_q  <= false_start_d;
      false_cnt_q    <= false_cnt_d;
      timeout_q      <= timeout_d;
      react_q        <= react_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign react        = react_q;
  assign busy         = busy_q;
  assign round_idx    = round_q;
  assign result_bcd   = result_q;
  assign result_valid = result_valid_q;
  assign best_bcd     = best_q;
  assign false_start  = false_start_q;
  assign false_cnt    = false_cnt_q;
  assign timeout      = timeout_q;
  assign session_done = done_q;

endmodule

// File: tb/tb_reaction_session_controller.sv
// Self-checking bench: expected results are queued when a response is driven
// and compared when result_valid fires.
module tb_reaction_session_controller;

  localparam int unsigned ROUNDS       = 5;
  localparam int unsigned TICKS_PER_MS = 1;
  localparam int unsigned MIN_DELAY_MS = 20;
  localparam int unsigned RAND_BITS    = 4;
  localparam int unsigned GAP_MS       = 2;
  localparam int          REACT_BOUND  = 200;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] best;
    logic        to;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_trigger;
  logic        user_trigger;
  logic        react;
  logic        busy;
  logic [2:0]  round_idx;
  logic [15:0] result_bcd;
  logic        result_valid;
  logic [15:0] best_bcd;
  logic        false_start;
  logic [3:0]  false_cnt;
  logic        timeout;
  logic        session_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  logic [15:0] model_best;

  reaction_session_controller #(
    .ROUNDS(ROUNDS), .TICKS_PER_MS(TICKS_PER_MS), .MIN_DELAY_MS(MIN_DELAY_MS),
    .RAND_BITS(RAND_BITS), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .rst(rst), .start_trigger(start_trigger), .user_trigger(user_trigger),
    .react(react), .busy(busy), .round_idx(round_idx), .result_bcd(result_bcd),
    .result_valid(result_valid), .best_bcd(best_bcd), .false_start(false_start),
    .false_cnt(false_cnt), .timeout(timeout), .session_done(session_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic push_exp(input int v, input logic to);
    exp_t e;
    e.res = to_bcd(v);
    if (e.res < model_best) model_best = e.res;
    e.best = model_best;
    e.to   = to;
    sb_q.push_back(e);
  endtask

  // Scoreboard side: compare every recorded result against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(result_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result_bcd", 32'(result_bcd), 32'(e.res));
          check("best_bcd", 32'(best_bcd), 32'(e.best));
          check("timeout_pulse", 32'(timeout), 32'(e.to));
        end
      end else begin
        if (timeout) check("stray_timeout", 32'(timeout), 32'd0);
      end
    end
  end

  task automatic wait_react(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < REACT_BOUND) begin
      @(posedge clk); #1;
      n++;
      if (react) ok = 1'b1;
    end
    if (!ok) check("react_wait", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start_trigger = 1'b1;
    @(posedge clk); #1;
    start_trigger = 1'b0;
    model_best = 16'h9999;
    check("start_busy", 32'(busy), 32'd1);
    check("start_best", 32'(best_bcd), 32'h9999);
    check("start_result", 32'(result_bcd), 32'h0);
    check("start_fcnt", 32'(false_cnt), 32'd0);
    check("start_round", 32'(round_idx), 32'd0);
    check("start_done", 32'(session_done), 32'd0);
  endtask

  // Press k cycles after react is first seen high; the count recorded equals k ms.
  task automatic respond(input int k);
    bit ok;
    int n;
    wait_react(ok, n);
    if (ok) begin
      repeat (k) @(posedge clk);
      #1;
      push_exp(k, 1'b0);
      user_trigger = 1'b1;
      @(posedge clk); #1;
      user_trigger = 1'b0;
      check("react_drop", 32'(react), 32'd0);
      @(posedge clk); #1;
      check("valid_width", 32'(result_valid), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int n;
    rst           = 1'b1;
    start_trigger = 1'b0;
    user_trigger  = 1'b0;
    model_best    = 16'h9999;
    repeat (3) @(posedge clk);
    #1;
    check("rst_react", 32'(react), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_round", 32'(round_idx), 32'd0);
    check("rst_result", 32'(result_bcd), 32'h0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_best", 32'(best_bcd), 32'h9999);
    check("rst_fcnt", 32'(false_cnt), 32'd0);
    check("rst_done", 32'(session_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Session 1: first round, then a burst of false starts.
    pulse_start();
    respond(37);
    check("round_after_first", 32'(round_idx), 32'd1);
    check("best_after_first", 32'(best_bcd), 32'h0037);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      user_trigger = 1'b1;
      @(posedge clk); #1;
      user_trigger = 1'b0;
      check("fs_pulse", 32'(false_start), 32'd1);
      check("fs_cnt", 32'(false_cnt), 32'((i + 1 > 15) ? 15 : i + 1));
      check("fs_round", 32'(round_idx), 32'd1);
      check("fs_react", 32'(react), 32'd0);
      @(posedge clk); #1;
      check("fs_width", 32'(false_start), 32'd0);
      @(posedge clk); #1;
    end
    wait_react(ok, n);
    check("fore_range", 32'(ok && n >= int'(MIN_DELAY_MS) &&
                           n <= int'(MIN_DELAY_MS + (1 << RAND_BITS) + 2)), 32'd1);
    // Let the round time out quickly is not wanted here; wait for react to drop via a press.
    if (ok) begin
      push_exp(0, 1'b0);
      user_trigger = 1'b1;
      @(posedge clk); #1;
      user_trigger = 1'b0;
      @(posedge clk); #1;
    end
    respond(120);
    respond(85);
    respond(300);
    check("s1_done", 32'(session_done), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_round", 32'(round_idx), 32'd4);
    check("s1_best", 32'(best_bcd), 32'h0000);

    // Session 2: full five-round session with a repeated best.
    pulse_start();
    respond(120);
    respond(85);
    respond(300);
    respond(85);
    respond(90);
    check("s2_best", 32'(best_bcd), 32'h0085);
    check("s2_done", 32'(session_done), 32'd1);
    check("s2_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("s2_hold", 32'(result_bcd), 32'h0090);

    // Session 3: tick/press coincidence, carries, timeout, reset during react.
    pulse_start();
    respond(9);
    respond(100);
    respond(1000);
    wait_react(ok, n);
    if (ok) begin
      push_exp(9999, 1'b1);
      n = 0;
      while (react && n < 10200) begin
        @(posedge clk); #1;
        n++;
      end
      check("timeout_end", 32'(react), 32'd0);
      check("timeout_len", 32'(n), 32'd10000);
    end
    wait_react(ok, n);
    if (ok) begin
      repeat (456) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_react", 32'(react), 32'd0);
      check("mid_rst_result", 32'(result_bcd), 32'h0);
      check("mid_rst_best", 32'(best_bcd), 32'h9999);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(result_valid), 32'd0);
      check("mid_rst_round", 32'(round_idx), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_idle", 32'(busy), 32'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
